// File: rtl/iob_gpio_disp.sv
// Memory-mapped multiplexed 7-segment display driver.
// The CPU programs per-digit patterns and scan timing over a simple
// valid/ready bus. A small scan FSM steps through the digit slots, with
// an optional blanking gap between slots to suppress ghosting.
module iob_gpio_disp #(
    parameter int   N_DIGITS   = 4,
    parameter int   DATA_W     = 32,
    parameter int   ADDR_W     = 5,
    parameter int   PRESCALE_W = 16,
    parameter int   BLANK_W    = 8,
    parameter logic ANODE_ACT  = 1'b0,
    parameter logic CATH_ACT   = 1'b0,
    localparam int  IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic [N_DIGITS-1:0]   anode_o,
    output logic [7:0]            cathode_o,
    output logic [IDX_W-1:0]      digit_idx_o,
    output logic                  frame_tick_o
);

    localparam int CNT_W = (PRESCALE_W > BLANK_W) ? PRESCALE_W : BLANK_W;

    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_BLANK    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_MASK     = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(4);
    localparam int                A_DIGIT0   = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    // Configuration registers
    logic                  ctrl_en;
    logic                  ctrl_decode;
    logic [PRESCALE_W-1:0] prescale;
    logic [BLANK_W-1:0]    blank;
    logic [N_DIGITS-1:0]   mask;
    logic [7:0]            digits [N_DIGITS];

    // Scan FSM state
    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              wrap, wrap_nx;

    logic                  wr_en, rd_en;
    logic [PRESCALE_W-1:0] lane_mask;
    logic [DATA_W-1:0]     rd_val;
    logic [CNT_W-1:0]      dwell_load, blank_load;
    logic                  last_slot;
    logic [IDX_W-1:0]      idx_adv;
    logic [N_DIGITS-1:0]   anode_d;
    logic [7:0]            cath_d, seg, cur_digit;

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^wdata[DATA_W-1:PRESCALE_W];

    assign wr_en = valid && (|wstrb);
    assign rd_en = valid && !(|wstrb);

    function automatic logic [PRESCALE_W-1:0] merge(
        input logic [PRESCALE_W-1:0] old_val,
        input logic [PRESCALE_W-1:0] new_val,
        input logic [PRESCALE_W-1:0] m
    );
        return (old_val & ~m) | (new_val & m);
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Expand byte strobes into a per-bit write mask
    always_comb begin
        for (int b = 0; b < PRESCALE_W; b++) lane_mask[b] = wstrb[b/8];
    end

    // CPU register writes, honouring byte lanes
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_en     <= 1'b0;
            ctrl_decode <= 1'b0;
            prescale    <= PRESCALE_W'(1);
            blank       <= '0;
            mask        <= '1;
            // NOTE: the digit store is only a few flops, so it is reset to keep
            // power-up garbage off the display; larger RAMs should not be reset.
            for (int i = 0; i < N_DIGITS; i++) digits[i] <= '0;
        end else if (wr_en) begin
            if (address == A_CTRL && wstrb[0]) begin
                ctrl_en     <= wdata[0];
                ctrl_decode <= wdata[1];
            end
            if (address == A_PRESCALE)
                prescale <= merge(prescale, wdata[PRESCALE_W-1:0], lane_mask);
            if (address == A_BLANK)
                blank <= BLANK_W'(merge(PRESCALE_W'(blank), wdata[PRESCALE_W-1:0], lane_mask));
            if (address == A_MASK)
                mask <= N_DIGITS'(merge(PRESCALE_W'(mask), wdata[PRESCALE_W-1:0], lane_mask));
            for (int i = 0; i < N_DIGITS; i++) begin
                if (address == ADDR_W'(A_DIGIT0 + i))
                    digits[i] <= 8'(merge(PRESCALE_W'(digits[i]), wdata[PRESCALE_W-1:0], lane_mask));
            end
        end
    end

    // Read mux; unmapped addresses fall through to zero
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        rd_val = '0;
        if (address == A_CTRL)     rd_val = DATA_W'({ctrl_decode, ctrl_en});
        if (address == A_PRESCALE) rd_val = DATA_W'(prescale);
        if (address == A_BLANK)    rd_val = DATA_W'(blank);
        if (address == A_MASK)     rd_val = DATA_W'(mask);
        if (address == A_STATUS)   rd_val = DATA_W'({state, 4'(idx)});
        for (int i = 0; i < N_DIGITS; i++) begin
            if (address == ADDR_W'(A_DIGIT0 + i)) rd_val = DATA_W'(digits[i]);
        end
    end

    // Bus response: ready one cycle after valid, read data registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            ready <= valid;
            rdata <= rd_en ? rd_val : '0;
        end
    end

    assign dwell_load = (prescale == '0) ? '0 : CNT_W'(prescale) - CNT_W'(1);
    assign blank_load = CNT_W'(blank) - CNT_W'(1);
    assign last_slot  = (idx == IDX_W'(N_DIGITS - 1));
    assign idx_adv    = last_slot ? '0 : idx + IDX_W'(1);

    // Scan FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
            wrap  <= wrap_nx;
        end
    end

    // Scan FSM next state: dwell and blank lengths are latched on entry
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        wrap_nx  = 1'b0;
        if (!ctrl_en) begin
            state_nx = S_IDLE;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = S_DRIVE;
                    idx_nx   = '0;
                    cnt_nx   = dwell_load;
                end
                S_DRIVE: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end else if (blank != '0) begin
                        state_nx = S_BLANK;
                        cnt_nx   = blank_load;
                    end else begin
                        idx_nx  = idx_adv;
                        wrap_nx = last_slot;
                        cnt_nx  = dwell_load;
                    end
                end
                S_BLANK: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end else begin
                        state_nx = S_DRIVE;
                        idx_nx   = idx_adv;
                        wrap_nx  = last_slot;
                        cnt_nx   = dwell_load;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Scan FSM outputs: a masked slot keeps its time but stays dark
    always_comb begin
        anode_d   = {N_DIGITS{~ANODE_ACT}};
        cath_d    = {8{~CATH_ACT}};
        cur_digit = digits[idx];
        seg       = ctrl_decode ? {cur_digit[4], hex7(cur_digit[3:0])} : cur_digit;
        if (state == S_DRIVE && mask[idx]) begin
            anode_d[idx] = ANODE_ACT;
            cath_d       = seg ^ {8{~CATH_ACT}};
        end
    end

    // Register the pad-facing outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            anode_o      <= {N_DIGITS{~ANODE_ACT}};
            cathode_o    <= {8{~CATH_ACT}};
            digit_idx_o  <= '0;
            frame_tick_o <= 1'b0;
        end else begin
            anode_o      <= anode_d;
            cathode_o    <= cath_d;
            digit_idx_o  <= idx;
            frame_tick_o <= wrap;
        end
    end

endmodule

// File: tb/tb_iob_gpio_disp.sv
// Directed bench for iob_gpio_disp: register-map vector table plus scan
// sequences compared against a small slot-timing model.
module tb_iob_gpio_disp;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [4:0]  address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic [3:0]  anode_o;
    logic [7:0]  cathode_o;
    logic [1:0]  digit_idx_o;
    logic        frame_tick_o;

    int errors = 0;
    int checks = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0] dig [4];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;   // zero means read and compare against exp
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    iob_gpio_disp dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .address      (address),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .rdata        (rdata),
        .ready        (ready),
        .anode_o      (anode_o),
        .cathode_o    (cathode_o),
        .digit_idx_o  (digit_idx_o),
        .frame_tick_o (frame_tick_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic bus(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic rdy);
        @(negedge clk);
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        @(negedge clk);
        valid = 1'b0; wstrb = '0;
        rdy = ready;
        rd  = rdata;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic        rdy;
        bus(a, d, s, r, rdy);
        check($sformatf("wr_ready@%0d", a), 32'(rdy), 32'd1);
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        rdy;
        bus(a, 32'd0, 4'd0, r, rdy);
        check({name, "_ready"}, 32'(rdy), 32'd1);
        check(name, r, exp);
    endtask

    function automatic logic [7:0] seg_of(input logic [7:0] d, input logic dec);
        if (dec) return {d[4], hex_tab[d[3:0]]};
        return d;
    endfunction

    task automatic configure(input int p, input int b, input logic [3:0] m, input logic dec);
        wr(5'd0, 32'd0, 4'h1);
        wr(5'd1, 32'(p), 4'hF);
        wr(5'd2, 32'(b), 4'hF);
        wr(5'd3, 32'(m), 4'hF);
        wr(5'd0, {30'd0, dec, 1'b1}, 4'h1);
    endtask

    // Wait (bounded) for a frame tick; returns at the negedge where it is seen
    task automatic wait_tick(input string tag, output logic seen);
        int guard = 0;
        @(negedge clk);
        while (!frame_tick_o && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        seen = frame_tick_o;
        if (!seen) check({tag, "_tick_timeout"}, 32'(frame_tick_o), 32'd1);
    endtask

    // Compare outputs cycle by cycle against the slot-timing model, k=0 at the tick
    task automatic run_scan(input string tag, input int p, input int b, input logic [3:0] m,
                            input logic dec, input int cycles);
        int   d, slen, slot, w;
        logic act, seen;
        logic [14:0] exp_v, got_v;
        d    = (p < 1) ? 1 : p;
        slen = d + b;
        wait_tick(tag, seen);
        if (!seen) return;
        for (int k = 0; k < cycles; k++) begin
            slot  = (k / slen) % 4;
            w     = k % slen;
            act   = (w < d) && m[slot];
            exp_v = {act ? ~(4'b0001 << slot) : 4'hF,
                     act ? ~seg_of(dig[slot], dec) : 8'hFF,
                     2'(slot),
                     (k % (slen * 4)) == 0};
            got_v = {anode_o, cathode_o, digit_idx_o, frame_tick_o};
            check($sformatf("%s_k%0d{anode,cath,idx,tick}", tag, k), 32'(got_v), 32'(exp_v));
            @(negedge clk);
        end
    endtask

    initial begin
        logic seen;
        int   guard;

        rst = 1'b0; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_anode", 32'(anode_o), 32'hF);
        check("rst_cathode", 32'(cathode_o), 32'hFF);
        check("rst_idx", 32'(digit_idx_o), 32'd0);
        check("rst_tick", 32'(frame_tick_o), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b1;

        // Register map vectors
        vecs.push_back('{5'd0,  32'd0,         4'h0, 32'h0});
        vecs.push_back('{5'd1,  32'd0,         4'h0, 32'h1});
        vecs.push_back('{5'd2,  32'd0,         4'h0, 32'h0});
        vecs.push_back('{5'd3,  32'd0,         4'h0, 32'hF});
        vecs.push_back('{5'd4,  32'd0,         4'h0, 32'h0});
        vecs.push_back('{5'd8,  32'd0,         4'h0, 32'h0});
        vecs.push_back('{5'd1,  32'h0000ABCD,  4'h1, 32'h0});
        vecs.push_back('{5'd1,  32'd0,         4'h0, 32'h00CD});
        vecs.push_back('{5'd1,  32'h12345678,  4'h2, 32'h0});
        vecs.push_back('{5'd1,  32'd0,         4'h0, 32'h56CD});
        vecs.push_back('{5'd2,  32'hFFFFFFFF,  4'hF, 32'h0});
        vecs.push_back('{5'd2,  32'd0,         4'h0, 32'hFF});
        vecs.push_back('{5'd3,  32'hFFFFFFF0,  4'hF, 32'h0});
        vecs.push_back('{5'd3,  32'd0,         4'h0, 32'h0});
        vecs.push_back('{5'd3,  32'h0000000A,  4'h1, 32'h0});
        vecs.push_back('{5'd3,  32'd0,         4'h0, 32'hA});
        vecs.push_back('{5'd11, 32'h00001234,  4'h3, 32'h0});
        vecs.push_back('{5'd11, 32'd0,         4'h0, 32'h34});
        vecs.push_back('{5'd11, 32'h0000FFFF,  4'h2, 32'h0});
        vecs.push_back('{5'd11, 32'd0,         4'h0, 32'h34});
        vecs.push_back('{5'd5,  32'hFFFFFFFF,  4'hF, 32'h0});
        vecs.push_back('{5'd5,  32'd0,         4'h0, 32'h0});
        vecs.push_back('{5'd12, 32'd0,         4'h0, 32'h0});
        vecs.push_back('{5'd31, 32'd0,         4'h0, 32'h0});
        vecs.push_back('{5'd4,  32'hFFFFFFFF,  4'hF, 32'h0});
        vecs.push_back('{5'd4,  32'd0,         4'h0, 32'h0});
        vecs.push_back('{5'd0,  32'h000000FE,  4'h1, 32'h0});
        vecs.push_back('{5'd0,  32'd0,         4'h0, 32'h2});
        vecs.push_back('{5'd0,  32'h00000101,  4'h2, 32'h0});
        vecs.push_back('{5'd0,  32'd0,         4'h0, 32'h2});
        vecs.push_back('{5'd0,  32'h00000000,  4'h1, 32'h0});
        vecs.push_back('{5'd0,  32'd0,         4'h0, 32'h0});

        foreach (vecs[i]) begin
            if (vecs[i].strb != 4'h0) wr(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else rd($sformatf("vec%0d_addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
        end

        // Digit contents used by every scan scenario
        dig = '{8'h1A, 8'h05, 8'h3C, 8'h80};
        for (int i = 0; i < 4; i++) wr(5'(8 + i), 32'(dig[i]), 4'h1);

        configure(3, 0, 4'hF, 1'b0);
        run_scan("p3b0", 3, 0, 4'hF, 1'b0, 30);

        configure(2, 2, 4'hF, 1'b0);
        run_scan("p2b2", 2, 2, 4'hF, 1'b0, 36);

        configure(3, 0, 4'hF, 1'b1);
        run_scan("dec", 3, 0, 4'hF, 1'b1, 14);
        wait_tick("dec_slot0", seen);
        if (seen) begin
            check("dec_slot0_cathode", 32'(cathode_o), 32'h08);
            check("dec_slot0_anode", 32'(anode_o), 32'hE);
        end

        configure(2, 2, 4'b0101, 1'b0);
        run_scan("mask0101", 2, 2, 4'b0101, 1'b0, 36);

        configure(0, 1, 4'hF, 1'b1);
        run_scan("p0b1", 0, 1, 4'hF, 1'b1, 18);

        // Digit write during a long dwell: visible two cycles later, dwell not restarted
        configure(8, 0, 4'hF, 1'b0);
        wait_tick("live", seen);
        if (seen) begin
            @(negedge clk);                       // k=1: write cycle
            valid = 1'b1; address = 5'd8; wdata = 32'h55; wstrb = 4'h1;
            @(negedge clk);                       // k=2
            valid = 1'b0; wstrb = '0;
            check("live_k2_old", 32'(cathode_o), 32'hE5);
            @(negedge clk);                       // k=3
            check("live_k3_new", 32'(cathode_o), 32'hAA);
            check("live_k3_anode", 32'(anode_o), 32'hE);
            repeat (4) @(negedge clk);            // k=7
            check("live_k7_anode", 32'(anode_o), 32'hE);
            @(negedge clk);                       // k=8
            check("live_k8_anode", 32'(anode_o), 32'hD);
        end
        wr(5'd8, 32'(dig[0]), 4'h1);

        // EN cleared during slot 2, then re-enabled
        configure(3, 0, 4'hF, 1'b0);
        wait_tick("en", seen);
        if (seen) begin
            repeat (6) @(negedge clk);            // k=6: slot 2 starts
            check("en_slot2_idx", 32'(digit_idx_o), 32'd2);
            check("en_slot2_anode", 32'(anode_o), 32'hB);
            valid = 1'b1; address = 5'd0; wdata = 32'd0; wstrb = 4'h1;
            @(negedge clk);                       // k=7: EN now low
            valid = 1'b0; wstrb = '0;
            @(negedge clk);                       // k=8: FSM in IDLE
            check("en_k8_tick", 32'(frame_tick_o), 32'd0);
            @(negedge clk);                       // k=9: outputs follow
            check("en_off{anode,cath,idx,tick}",
                  32'({anode_o, cathode_o, digit_idx_o, frame_tick_o}), 32'({4'hF, 8'hFF, 2'd0, 1'b0}));
            rd("en_off_status", 5'd4, 32'h0);
            wr(5'd0, 32'd1, 4'h1);
            guard = 0;
            while (anode_o == 4'hF && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            check("en_restart_anode", 32'(anode_o), 32'hE);
            check("en_restart_idx", 32'(digit_idx_o), 32'd0);
            check("en_restart_tick", 32'(frame_tick_o), 32'd0);
        end

        // Reset mid-scan
        configure(3, 0, 4'hF, 1'b0);
        wait_tick("mrst", seen);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst{anode,cath,idx,tick}",
              32'({anode_o, cathode_o, digit_idx_o, frame_tick_o}), 32'({4'hF, 8'hFF, 2'd0, 1'b0}));
        rst = 1'b1;
        rd("mrst_ctrl", 5'd0, 32'h0);
        rd("mrst_prescale", 5'd1, 32'h1);
        rd("mrst_mask", 5'd3, 32'hF);
        rd("mrst_digit0", 5'd8, 32'h0);
        repeat (5) @(negedge clk);
        check("mrst_stays_dark", 32'(anode_o), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iob_gpio_disp.md
IOB_GPIO_DISP -- requirements
Module: iob_gpio_disp

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits; legal range 1..16.
REQ-002 Parameter DATA_W, default 32: CPU data width.
REQ-003 Parameter ADDR_W, default 5: CPU word-address width.
REQ-004 Parameter PRESCALE_W, default 16: width of the per-digit dwell counter.
REQ-005 Parameter BLANK_W, default 8: width of the inter-digit blanking counter.
REQ-006 Parameters ANODE_ACT and CATH_ACT, default 1'b0 each: active level of anode_o and cathode_o bits.
REQ-007 The block SHALL have one clock, clk; reset rst is synchronous and active-low.
REQ-008 Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- valid  in  1  CPU request
- address  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte write strobes; all zero means read
- rdata  out  DATA_W  read data
- ready  out  1  request done
- anode_o  out  N_DIGITS  digit selects
- cathode_o  out  8  segments a..g on bits 0..6, dp on bit 7
- digit_idx_o  out  clog2(N_DIGITS), min 1  current scan slot
- frame_tick_o  out  1  one-cycle pulse at scan-frame wrap

Function
REQ-009 Register map, word addresses:
- 0 CTRL RW: bit0 EN, bit1 DECODE
- 1 PRESCALE RW: PRESCALE_W bits
- 2 BLANK RW: BLANK_W bits
- 3 MASK RW: N_DIGITS bits
- 4 STATUS RO: [3:0] idx, [5:4] state
- 8+i DIGIT[i] RW: 8 bits, for i < N_DIGITS
REQ-010 ready SHALL assert exactly one cycle after each valid cycle; rdata SHALL be registered and valid while ready is high.
REQ-011 Writes SHALL honour wstrb per byte lane; unused register bits SHALL read 0.
REQ-012 Unmapped addresses SHALL read 0, SHALL ignore writes, and SHALL still return ready.
REQ-013 The FSM SHALL have states IDLE (0), DRIVE (1) and BLANK (2).
REQ-014 From IDLE with EN=1, the next cycle SHALL enter DRIVE with idx=0.
REQ-015 DRIVE SHALL last max(PRESCALE,1) cycles, with PRESCALE sampled on DRIVE entry. Exit goes to BLANK if BLANK>0, else directly to the next slot's DRIVE.
REQ-016 BLANK SHALL last BLANK cycles, sampled on BLANK entry, then enter DRIVE of the next slot.
REQ-017 Slot advance SHALL set idx=idx+1. At idx=N_DIGITS-1 it SHALL wrap to 0 and pulse frame_tick_o for one cycle.
REQ-018 Masked digits (MASK[i]=0) SHALL keep their time slot, with anode held inactive, so brightness is independent of the mask.
REQ-019 In DRIVE on an unmasked slot:
- anode_o[idx] SHALL be active and all other anode bits inactive.
- cathode_o SHALL show the segment pattern of DIGIT[idx], XOR-adjusted for CATH_ACT.
REQ-020 In IDLE, BLANK or a masked slot, all anode_o and cathode_o bits SHALL be inactive.
REQ-021 With DECODE=0, the segment pattern SHALL be DIGIT[idx][7:0] raw.
REQ-022 With DECODE=1, the segment pattern SHALL be hex-decode(DIGIT[idx][3:0]), with dp taken from DIGIT[idx][4]. Decode table for 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-023 anode_o, cathode_o, digit_idx_o and frame_tick_o SHALL be registered, lagging the FSM state by one cycle.
REQ-024 A DIGIT, DECODE or MASK write during DRIVE SHALL affect outputs two cycles after the write cycle, without restarting the dwell.
REQ-025 EN cleared in any state SHALL force IDLE on the next cycle, with idx=0, counters cleared and no frame_tick.
REQ-026 A PRESCALE or BLANK write during a slot SHALL apply from the next state entry.

Reset
REQ-027 rst low at a clk edge SHALL clear all registers, set state IDLE and idx 0, and drive anode_o and cathode_o inactive (replicated ~ANODE_ACT and ~CATH_ACT).
REQ-028 After reset, rdata, ready, digit_idx_o and frame_tick_o SHALL be 0.
REQ-029 After reset, MASK SHALL be all ones and PRESCALE SHALL be 1.
REQ-030 Reset mid-scan SHALL take effect on the same edge, with no partial slot completing afterward.

Verification
REQ-031 Reset, then read addresses 0..4 -> values 0, 1, 0, 0xF, 0; anode_o=4'hF, cathode_o=8'hFF (active-low defaults).
REQ-032 PRESCALE=3, BLANK=0, EN=1 -> each anode goes low for exactly 3 cycles in order 0,1,2,3, and frame_tick_o pulses every 12 cycles.
REQ-033 PRESCALE=2, BLANK=2 -> each slot is 2 cycles driven plus 2 cycles with all anodes high; frame period is 16 cycles.
REQ-034 DECODE=1, DIGIT0=0x1A -> cathode_o=~(0x77|0x80)=8'h08 while slot 0 is driven.
REQ-035 MASK=4'b0101 -> anodes 1 and 3 never go active, and the frame period is unchanged.
REQ-036 EN cleared during slot 2 -> IDLE next cycle and outputs inactive; re-enabling restarts at slot 0.
